// File: rtl/intm_rs.sv
// Age-ordered reservation station for the multiply/divide unit.
// Optional macro INTM_RS_CDB_BYPASS_EN: same-cycle CDB capture at dispatch.
module intm_rs #(
  parameter int DEPTH = 4,
  parameter int PRF_W = 6,
  parameter int ROB_W = 5
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              flush,
  input  logic                              dis_valid,
  output logic                              dis_ready,
  input  logic [2:0]                        dis_opcode,
  input  logic [ROB_W-1:0]                  dis_rob_id,
  input  logic [4:0]                        dis_rd_arch,
  input  logic [PRF_W-1:0]                  dis_rd_phy,
  input  logic [PRF_W-1:0]                  dis_rs1_phy,
  input  logic [PRF_W-1:0]                  dis_rs2_phy,
  input  logic                              dis_rs1_rdy,
  input  logic                              dis_rs2_rdy,
  input  logic [31:0]                       dis_rs1_val,
  input  logic [31:0]                       dis_rs2_val,
  input  logic                              cdb_valid,
  input  logic [PRF_W-1:0]                  cdb_rd_phy,
  input  logic [31:0]                       cdb_rd_value,
  output logic                              iss_valid,
  input  logic                              iss_ready,
  output logic [2:0]                        iss_opcode,
  output logic [ROB_W-1:0]                  iss_rob_id,
  output logic [4:0]                        iss_rd_arch,
  output logic [PRF_W-1:0]                  iss_rd_phy,
  output logic [31:0]                       iss_rs1_val,
  output logic [31:0]                       iss_rs2_val,
  output logic [$clog2(DEPTH+1)-1:0]        dbg_count,
  output logic                              dbg_locked
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [2:0]       opcode;
    logic [ROB_W-1:0] rob_id;
    logic [4:0]       rd_arch;
    logic [PRF_W-1:0] rd_phy;
    logic [PRF_W-1:0] rs1_tag;
    logic             rs1_rdy;
    logic [31:0]      rs1_val;
    logic [PRF_W-1:0] rs2_tag;
    logic             rs2_rdy;
    logic [31:0]      rs2_val;
  } entry_t;

  entry_t           ent_q [DEPTH];
  entry_t           ent_d [DEPTH];
  entry_t           woke  [DEPTH];
  entry_t           new_ent;
  entry_t           sel_ent;
  logic [CNT_W-1:0] count_q, count_d, alloc_slot;
  logic             lock_q, lock_d;
  logic [IDX_W-1:0] lock_idx_q, lock_idx_d, oldest, sel_idx;
  logic             any_elig, cdb_hit, alloc, issue;

  // Handshakes: a dispatch transfers on dis_valid && dis_ready (dropped on
  // flush); an issue transfers on iss_valid && iss_ready, and once iss_valid
  // is shown with iss_ready low the offered uop is held until accepted.
  assign cdb_hit   = cdb_valid && (cdb_rd_phy != '0);
  assign dis_ready = (count_q < CNT_W'(DEPTH));
  assign alloc     = dis_valid && dis_ready && !flush;
  assign issue     = iss_valid && iss_ready;
  assign dbg_count = count_q;
  assign dbg_locked = lock_q;

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      woke[i] = ent_q[i];
      if (cdb_hit && !woke[i].rs1_rdy && woke[i].rs1_tag == cdb_rd_phy) begin
        woke[i].rs1_rdy = 1'b1;
        woke[i].rs1_val = cdb_rd_value;
      end
      if (cdb_hit && !woke[i].rs2_rdy && woke[i].rs2_tag == cdb_rd_phy) begin
        woke[i].rs2_rdy = 1'b1;
        woke[i].rs2_val = cdb_rd_value;
      end
    end
  end

  always_comb begin
    new_ent = '{opcode: dis_opcode, rob_id: dis_rob_id, rd_arch: dis_rd_arch,
                rd_phy: dis_rd_phy, rs1_tag: dis_rs1_phy, rs1_rdy: dis_rs1_rdy,
                rs1_val: dis_rs1_val, rs2_tag: dis_rs2_phy, rs2_rdy: dis_rs2_rdy,
                rs2_val: dis_rs2_val};
`ifdef INTM_RS_CDB_BYPASS_EN
    if (cdb_hit && !dis_rs1_rdy && dis_rs1_phy == cdb_rd_phy) begin
      new_ent.rs1_rdy = 1'b1;
      new_ent.rs1_val = cdb_rd_value;
    end
    if (cdb_hit && !dis_rs2_rdy && dis_rs2_phy == cdb_rd_phy) begin
      new_ent.rs2_rdy = 1'b1;
      new_ent.rs2_val = cdb_rd_value;
    end
`endif
  end

  // Scan youngest to oldest so the last hit is the oldest eligible slot.
  always_comb begin
    any_elig = 1'b0;
    oldest   = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (CNT_W'(i) < count_q && ent_q[i].rs1_rdy && ent_q[i].rs2_rdy) begin
        any_elig = 1'b1;
        oldest   = IDX_W'(i);
      end
    end
    sel_idx   = lock_q ? lock_idx_q : oldest;
    iss_valid = lock_q || any_elig;
    sel_ent   = ent_q[sel_idx];
  end

  always_comb begin
    iss_opcode  = '0;
    iss_rob_id  = '0;
    iss_rd_arch = '0;
    iss_rd_phy  = '0;
    iss_rs1_val = '0;
    iss_rs2_val = '0;
    if (iss_valid) begin
      iss_opcode  = sel_ent.opcode;
      iss_rob_id  = sel_ent.rob_id;
      iss_rd_arch = sel_ent.rd_arch;
      iss_rd_phy  = sel_ent.rd_phy;
      iss_rs1_val = sel_ent.rs1_val;
      iss_rs2_val = sel_ent.rs2_val;
    end
  end

  // Collapse younger slots over the issued one, then append at the new tail.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) ent_d[i] = woke[i];
    if (issue) begin
      for (int i = 0; i < DEPTH - 1; i++)
        if (IDX_W'(i) >= sel_idx) ent_d[i] = woke[i+1];
      ent_d[DEPTH-1] = '0;
    end
    alloc_slot = count_q - CNT_W'(issue);
    for (int i = 0; i < DEPTH; i++)
      if (alloc && CNT_W'(i) == alloc_slot) ent_d[i] = new_ent;
    count_d    = count_q + CNT_W'(alloc) - CNT_W'(issue);
    lock_d     = iss_valid && !iss_ready;
    lock_idx_d = sel_idx;
    if (flush) begin
      for (int i = 0; i < DEPTH; i++) ent_d[i] = '0;
      count_d = '0;
      lock_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q    <= '0;
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
    end else begin
      count_q    <= count_d;
      lock_q     <= lock_d;
      lock_idx_q <= lock_idx_d;
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= ent_d[i];
    end
  end

endmodule
